// File: rtl/execute_mc_pkg.sv
// rtl/execute_mc_pkg.sv - op codes, branch codes and FSM state for execute_mc
package exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ANDN = 4'd3;
  localparam logic [3:0] OP_ROL  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_ROR  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SEQ  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLE  = 4'd10;
  localparam logic [3:0] OP_SCO  = 4'd11;
  localparam logic [3:0] OP_BTR  = 4'd12;
  localparam logic [3:0] OP_LBI  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_DIVU = 4'd15;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQZ = 3'b100;
  localparam logic [2:0] BR_BNEZ = 3'b101;
  localparam logic [2:0] BR_BLTZ = 3'b110;
  localparam logic [2:0] BR_BGEZ = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/execute_mc_if.sv
// rtl/execute_mc_if.sv - decode-side and memory-side handshake bundle of execute_mc
interface execute_mc_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] imm;
  logic             use_imm;
  logic [WIDTH-1:0] inc_pc;
  logic [2:0]       br_cond;
  logic             jump;
  logic             jump_reg;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] new_pc;
  logic             pc_src;
  logic             ofl;

  modport master (
    output in_valid, op, a, b, imm, use_imm, inc_pc, br_cond, jump, jump_reg, out_ready,
    input  in_ready, out_valid, result, new_pc, pc_src, ofl
  );

  modport slave (
    input  in_valid, op, a, b, imm, use_imm, inc_pc, br_cond, jump, jump_reg, out_ready,
    output in_ready, out_valid, result, new_pc, pc_src, ofl
  );
endinterface

// File: rtl/execute_mc_iter.sv
// rtl/execute_mc_iter.sv - shared radix-2 shift-add multiplier / restoring divider
module exec_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic             hi_nz,
  output logic             div0
);
  localparam int CW = $clog2(WIDTH);

  // hi is the product high half for MUL and the partial remainder for DIVU;
  // lo starts as multiplier/dividend and ends as product low half/quotient.
  logic [WIDTH-1:0] hi, lo_q, m;
  logic             div_q, zero_q, run;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   add_s, trial;

  always_comb begin
    add_s = {1'b0, hi} + {1'b0, (lo_q[0] ? m : '0)};
    trial = {hi, lo_q[WIDTH-1]} - {1'b0, m};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi     <= '0;
      lo_q   <= '0;
      m      <= '0;
      div_q  <= 1'b0;
      zero_q <= 1'b0;
      run    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        hi     <= '0;
        lo_q   <= a;
        m      <= b;
        div_q  <= is_div;
        zero_q <= (b == '0);
        run    <= 1'b1;
        cnt    <= '0;
      end else if (run) begin
        if (div_q) begin
          // A zero divisor never borrows, so the quotient saturates to all ones.
          if (!trial[WIDTH]) begin
            hi   <= trial[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi   <= {hi[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi   <= add_s[WIDTH:1];
          lo_q <= {add_s[0], lo_q[WIDTH-1:1]};
        end
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign lo    = lo_q;
  assign hi_nz = ~div_q & (|hi);
  assign div0  = div_q & zero_q;

endmodule

// File: rtl/execute_mc.sv
// rtl/execute_mc.sv - multi-cycle execute stage: 1-cycle ALU/branch ops, iterative MUL/DIVU
module execute_mc
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst,
  execute_mc_if.slave bus
);
  state_t           state;
  logic [WIDTH-1:0] bv, diff, alu_res, tgt, result_q, new_pc_q, iter_lo;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic             alu_ofl, cond, accept, iter_start;
  logic             iter_done, iter_hi_nz, iter_div0;
  logic             out_valid_q, pc_src_q, ofl_q;

  always_comb begin
    bv      = bus.use_imm ? bus.imm : bus.b;
    sum     = {1'b0, bus.a} + {1'b0, bv};
    diff    = bus.a - bv;
    sh      = bv[SHW-1:0];
    alu_res = '0;
    alu_ofl = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_ofl = (bus.a[WIDTH-1] == bv[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ofl = (bus.a[WIDTH-1] != bv[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_XOR:  alu_res = bus.a ^ bv;
      OP_ANDN: alu_res = bus.a & ~bv;
      // Shifting by WIDTH yields zero, which keeps the zero-amount rotate correct.
      OP_ROL:  alu_res = (bus.a << sh) | (bus.a >> (WIDTH - int'(sh)));
      OP_SLL:  alu_res = bus.a << sh;
      OP_ROR:  alu_res = (bus.a >> sh) | (bus.a << (WIDTH - int'(sh)));
      OP_SRL:  alu_res = bus.a >> sh;
      OP_SEQ:  alu_res = WIDTH'(bus.a == bv);
      OP_SLT:  alu_res = WIDTH'($signed(bus.a) < $signed(bv));
      OP_SLE:  alu_res = WIDTH'($signed(bus.a) <= $signed(bv));
      OP_SCO:  alu_res = WIDTH'(sum[WIDTH]);
      OP_BTR:  for (int i = 0; i < WIDTH; i++) alu_res[i] = bus.a[WIDTH-1-i];
      OP_LBI:  alu_res = bus.imm;
      default: alu_res = '0;
    endcase

    case (bus.br_cond)
      BR_BEQZ: cond = (bus.a == '0);
      BR_BNEZ: cond = (bus.a != '0);
      BR_BLTZ: cond = bus.a[WIDTH-1];
      BR_BGEZ: cond = ~bus.a[WIDTH-1];
      default: cond = 1'b0;
    endcase
    tgt = (bus.jump_reg ? bus.a : bus.inc_pc) + bus.imm;
  end

  assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign iter_start   = accept && is_iter_op(bus.op);

  exec_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .is_div (bus.op == OP_DIVU),
    .a      (bus.a),
    .b      (bv),
    .done   (iter_done),
    .lo     (iter_lo),
    .hi_nz  (iter_hi_nz),
    .div0   (iter_div0)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      new_pc_q    <= '0;
      pc_src_q    <= 1'b0;
      ofl_q       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            // Redirect fields are captured now; out_valid stays low until the op finishes.
            new_pc_q <= tgt;
            pc_src_q <= bus.jump | cond;
            if (is_iter_op(bus.op)) begin
              state       <= BUSY;
              out_valid_q <= 1'b0;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              ofl_q       <= alu_ofl;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        BUSY: begin
          if (iter_done) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= iter_lo;
            ofl_q       <= iter_hi_nz | iter_div0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.new_pc    = new_pc_q;
  assign bus.pc_src    = pc_src_q;
  assign bus.ofl       = ofl_q;

endmodule

// File: tb/tb_execute_mc.sv
// tb/tb_execute_mc.sv - scoreboard bench for execute_mc at WIDTH 16 (plus one WIDTH 32 rotate)
module tb_execute_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  execute_mc_if #(.WIDTH(16)) bus ();
  execute_mc_if #(.WIDTH(32)) bus32 ();

  execute_mc #(.WIDTH(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  execute_mc #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  typedef struct packed {
    logic [15:0] res;
    logic        ofl;
    logic        pc_src;
    logic [15:0] new_pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t obs_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  bit   last_in_ready;

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, b, imm,
                                 input logic use_imm, input logic [15:0] inc_pc,
                                 input logic [2:0] brc, input logic jump, jr);
    exp_t e;
    logic [15:0] bv, r;
    logic [31:0] p;
    int sa, sb, s;
    logic taken;
    bv = use_imm ? imm : b;
    sa = $signed(a);
    sb = $signed(bv);
    r = '0;
    e.ofl = 1'b0;
    case (op)
      4'd0: begin s = sa + sb; r = a + bv; e.ofl = (s > 32767) || (s < -32768); end
      4'd1: begin s = sa - sb; r = a - bv; e.ofl = (s > 32767) || (s < -32768); end
      4'd2: r = a ^ bv;
      4'd3: r = a & ~bv;
      4'd4: begin r = a; for (int i = 0; i < int'(bv[3:0]); i++) r = {r[14:0], r[15]}; end
      4'd5: r = a << bv[3:0];
      4'd6: begin r = a; for (int i = 0; i < int'(bv[3:0]); i++) r = {r[0], r[15:1]}; end
      4'd7: r = a >> bv[3:0];
      4'd8: r = (a == bv) ? 16'd1 : 16'd0;
      4'd9: r = (sa < sb) ? 16'd1 : 16'd0;
      4'd10: r = (sa <= sb) ? 16'd1 : 16'd0;
      4'd11: r = (({16'd0, a} + {16'd0, bv}) > 32'h0000_FFFF) ? 16'd1 : 16'd0;
      4'd12: for (int i = 0; i < 16; i++) r[i] = a[15-i];
      4'd13: r = imm;
      4'd14: begin p = {16'd0, a} * {16'd0, bv}; r = p[15:0]; e.ofl = (p[31:16] != 16'd0); end
      default: begin
        if (bv == 16'd0) begin r = 16'hFFFF; e.ofl = 1'b1; end
        else r = a / bv;
      end
    endcase
    case (brc)
      3'b100: taken = (a == 16'd0);
      3'b101: taken = (a != 16'd0);
      3'b110: taken = (sa < 0);
      3'b111: taken = (sa >= 0);
      default: taken = 1'b0;
    endcase
    e.res    = r;
    e.pc_src = jump | taken;
    e.new_pc = (jr ? a : inc_pc) + imm;
    return e;
  endfunction

  // Every wait goes through tick so that each consumed result lands in obs_q.
  task automatic tick();
    exp_t o;
    @(negedge clk);
    last_in_ready = bus.in_ready;
    if (rst && bus.out_valid && bus.out_ready) begin
      o.res = bus.result; o.ofl = bus.ofl; o.pc_src = bus.pc_src; o.new_pc = bus.new_pc;
      obs_q.push_back(o);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, b, imm, input logic use_imm,
                       input logic [15:0] inc_pc, input logic [2:0] brc, input logic jump, jr,
                       output int waited);
    bus.op = op; bus.a = a; bus.b = b; bus.imm = imm; bus.use_imm = use_imm;
    bus.inc_pc = inc_pc; bus.br_cond = brc; bus.jump = jump; bus.jump_reg = jr;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(op, a, b, imm, use_imm, inc_pc, brc, jump, jr));
    waited = 0;
    do begin tick(); waited++; end while (!last_in_ready && waited < 100);
    bus.in_valid = 1'b0;
    n_checks++;
    if (!last_in_ready) begin
      n_fails++;
      $display("FAIL issue_accept: op %0d not accepted within %0d cycles", op, waited);
    end
  endtask

  function automatic logic [2:0] rand_brc();
    if ($urandom_range(0, 4) == 0) return 3'b000;
    return 3'(4 + $urandom_range(0, 3));
  endfunction

  task automatic test_reset();
    bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.imm = 0; bus.use_imm = 0;
    bus.inc_pc = 0; bus.br_cond = 0; bus.jump = 0; bus.jump_reg = 0; bus.out_ready = 1;
    bus32.in_valid = 0; bus32.op = 0; bus32.a = 0; bus32.b = 0; bus32.imm = 0; bus32.use_imm = 0;
    bus32.inc_pc = 0; bus32.br_cond = 0; bus32.jump = 0; bus32.jump_reg = 0; bus32.out_ready = 1;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    n_checks += 6;
    if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (bus.result !== 16'h0) begin n_fails++; $display("FAIL reset_result: got %h want 0000", bus.result); end
    if (bus.new_pc !== 16'h0) begin n_fails++; $display("FAIL reset_new_pc: got %h want 0000", bus.new_pc); end
    if (bus.pc_src !== 1'b0) begin n_fails++; $display("FAIL reset_pc_src: got %b want 0", bus.pc_src); end
    if (bus.ofl !== 1'b0) begin n_fails++; $display("FAIL reset_ofl: got %b want 0", bus.ofl); end
  endtask

  task automatic test_add_latency();
    int w;
    exp_t e, o;
    issue(4'd0, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL add_latency: out_valid %b want 1 one cycle after accept", bus.out_valid); end
    n_checks++;
    if (bus.result !== 16'h8000 || bus.ofl !== 1'b1) begin
      n_fails++; $display("FAIL add_overflow: got %h ofl %b want 8000 ofl 1", bus.result, bus.ofl);
    end
    tick();
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL add_sb: got %h/%b/%b/%h want %h/%b/%b/%h", o.res, o.ofl, o.pc_src, o.new_pc, e.res, e.ofl, e.pc_src, e.new_pc); end
    end
  endtask

  task automatic test_alu();
    int w;
    exp_t e, o;
    issue(4'd9,  16'h8000, 16'h7FFF, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    issue(4'd11, 16'hFFFF, 16'h0000, 16'h0001, 1'b1, 16'h0, 3'b000, 1'b0, 1'b0, w);
    issue(4'd6,  16'h0001, 16'h0001, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    issue(4'd12, 16'h0001, 16'h0000, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    issue(4'd1,  16'h8000, 16'h0001, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    issue(4'd10, 16'h8000, 16'h7FFF, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    for (int k = 0; k < 42; k++)
      issue(4'(k % 14), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
            rand_brc(), 1'($urandom), 1'($urandom), w);
    repeat (2) tick();
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL alu_sb: got %h/%b/%b/%h want %h/%b/%b/%h", o.res, o.ofl, o.pc_src, o.new_pc, e.res, e.ofl, e.pc_src, e.new_pc); end
    end
  endtask

  task automatic test_mul_div();
    int w;
    exp_t e, o;
    issue(4'd14, 16'h0100, 16'h0100, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    // The next op waits out the MUL; its operands also overwrite the MUL's inputs mid-run.
    issue(4'd15, 16'd100, 16'd7, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    n_checks++;
    if (w - 1 !== 17) begin n_fails++; $display("FAIL mul_in_ready_low: got %0d cycles want 17", w - 1); end
    issue(4'd15, 16'h1234, 16'h0000, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    for (int k = 0; k < 6; k++)
      issue(4'(14 + (k % 2)), 16'($urandom), 16'($urandom_range(1, 300)), 16'($urandom), 1'b0,
            16'($urandom), rand_brc(), 1'($urandom), 1'($urandom), w);
    for (int k = 0; k < 40 && obs_q.size() < exp_q.size(); k++) tick();
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL muldiv_sb: got %h/%b/%b/%h want %h/%b/%b/%h", o.res, o.ofl, o.pc_src, o.new_pc, e.res, e.ofl, e.pc_src, e.new_pc); end
    end
  endtask

  task automatic test_branch();
    int w;
    exp_t e, o;
    issue(4'd2, 16'h0003, 16'h0000, 16'hFFFC, 1'b0, 16'h0010, 3'b101, 1'b0, 1'b0, w);
    n_checks++;
    if (bus.pc_src !== 1'b1 || bus.new_pc !== 16'h000C) begin
      n_fails++; $display("FAIL bnez: got pc_src %b new_pc %h want 1 000C", bus.pc_src, bus.new_pc);
    end
    issue(4'd0, 16'h0100, 16'h0000, 16'h0004, 1'b0, 16'h0010, 3'b000, 1'b1, 1'b1, w);
    n_checks++;
    if (bus.pc_src !== 1'b1 || bus.new_pc !== 16'h0104) begin
      n_fails++; $display("FAIL jump_reg: got pc_src %b new_pc %h want 1 0104", bus.pc_src, bus.new_pc);
    end
    issue(4'd0, 16'h0003, 16'h0000, 16'h0008, 1'b0, 16'hFFFC, 3'b100, 1'b0, 1'b0, w);
    issue(4'd0, 16'h8001, 16'h0000, 16'h0002, 1'b0, 16'h0020, 3'b110, 1'b0, 1'b0, w);
    issue(4'd0, 16'h8001, 16'h0000, 16'h0002, 1'b0, 16'h0020, 3'b111, 1'b0, 1'b0, w);
    repeat (2) tick();
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL branch_sb: got %h/%b/%b/%h want %h/%b/%b/%h", o.res, o.ofl, o.pc_src, o.new_pc, e.res, e.ofl, e.pc_src, e.new_pc); end
    end
  endtask

  task automatic test_stall();
    int w;
    exp_t e, o;
    bus.out_ready = 1'b0;
    issue(4'd0, 16'h0001, 16'h0002, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks += 2;
      if (bus.out_valid !== 1'b1 || bus.result !== 16'h0003) begin
        n_fails++; $display("FAIL stall_hold: cycle %0d got valid %b result %h want 1 0003", k, bus.out_valid, bus.result);
      end
      if (last_in_ready !== 1'b0) begin n_fails++; $display("FAIL stall_in_ready: cycle %0d got %b want 0", k, last_in_ready); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL stall_sb: got %h/%b/%b/%h want %h/%b/%b/%h", o.res, o.ofl, o.pc_src, o.new_pc, e.res, e.ofl, e.pc_src, e.new_pc); end
    end
  endtask

  task automatic test_back_to_back();
    int w, c0;
    exp_t e, o;
    c0 = cyc;
    for (int k = 0; k < 20; k++)
      issue(4'($urandom_range(0, 13)), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
            16'($urandom), rand_brc(), 1'($urandom), 1'($urandom), w);
    n_checks++;
    if (cyc - c0 !== 20) begin n_fails++; $display("FAIL back_to_back: 20 ops took %0d cycles want 20", cyc - c0); end
    repeat (2) tick();
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL b2b_sb: got %h/%b/%b/%h want %h/%b/%b/%h", o.res, o.ofl, o.pc_src, o.new_pc, e.res, e.ofl, e.pc_src, e.new_pc); end
    end
  endtask

  task automatic test_reset_mid_mul();
    int w;
    exp_t e, o;
    issue(4'd14, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    void'(exp_q.pop_back());
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks += 2;
    if (bus.out_valid !== 1'b0 || bus.result !== 16'h0) begin
      n_fails++; $display("FAIL rst_mid_mul: got valid %b result %h want 0 0000", bus.out_valid, bus.result);
    end
    if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL rst_mid_mul_idle: in_ready %b want 1", bus.in_ready); end
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL rst_mid_mul_ghost: out_valid %b want 0 at cycle %0d", bus.out_valid, k); end
    end
    issue(4'd0, 16'h0005, 16'h0006, 16'h0, 1'b0, 16'h0, 3'b000, 1'b0, 1'b0, w);
    repeat (2) tick();
    n_checks++;
    if (obs_q.size() !== 1) begin n_fails++; $display("FAIL rst_after_add: got %0d results want 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fails++; $display("FAIL rst_add_sb: got %h/%b/%b/%h want %h/%b/%b/%h", o.res, o.ofl, o.pc_src, o.new_pc, e.res, e.ofl, e.pc_src, e.new_pc); end
    end
  endtask

  task automatic test_w32();
    bus32.op = 4'd6; bus32.a = 32'h1; bus32.b = 32'h1; bus32.use_imm = 1'b0; bus32.out_ready = 1'b1;
    bus32.in_valid = 1'b1;
    tick();
    bus32.in_valid = 1'b0;
    n_checks++;
    if (bus32.out_valid !== 1'b1 || bus32.result !== 32'h8000_0000) begin
      n_fails++; $display("FAIL ror_w32: got valid %b result %h want 1 80000000", bus32.out_valid, bus32.result);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_alu();
    test_mul_div();
    test_branch();
    test_stall();
    test_back_to_back();
    test_reset_mid_mul();
    test_w32();
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fails++; $display("FAIL sb_leftover: %0d expected and %0d observed left, want 0 and 0", exp_q.size(), obs_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1);
  end

endmodule
